// File: rtl/usb_tx_pkg.sv
// -----------------------------------------------------------------------------
// usb_tx_pkg
// Shared definitions for the USB TX arbiter:
//   - packet type codes carried on req_packet / tx_packet
//   - arbiter state encoding
//   - default largest legal DATA payload
// -----------------------------------------------------------------------------
package usb_tx_pkg;

    localparam logic [1:0] PKT_NONE = 2'b00;
    localparam logic [1:0] PKT_DATA = 2'b01;
    localparam logic [1:0] PKT_ACK  = 2'b10;
    localparam logic [1:0] PKT_NAK  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int MAX_SIZE_DEFAULT = 64;

endpackage

// File: rtl/usb_tx_arb_pick.sv
// -----------------------------------------------------------------------------
// usb_tx_arb_pick
// Combinational picker: returns the first eligible requester found when
// searching upward (with wrap) from index 'start'. start = 0 gives plain
// lowest-index-wins priority.
// Ports:
//   eligible [NUM_REQ]  requesters that may be granted
//   start    [PTR_W]    first index to examine (must be < NUM_REQ)
//   valid               at least one requester is eligible
//   idx      [PTR_W]    chosen requester (0 when valid is low)
// -----------------------------------------------------------------------------
module usb_tx_arb_pick #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   start,
    output logic               valid,
    output logic [PTR_W-1:0]   idx
);

    // pos_arr[k] is the requester examined k-th; rot[k] its eligibility.
    logic [PTR_W-1:0]   pos_arr [NUM_REQ];
    logic [NUM_REQ-1:0] rot;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            logic [PTR_W:0] sum;
            assign sum         = {1'b0, start} + (PTR_W+1)'(gi);
            assign pos_arr[gi] = (sum >= (PTR_W+1)'(NUM_REQ)) ?
                                 PTR_W'(sum - (PTR_W+1)'(NUM_REQ)) : PTR_W'(sum);
            assign rot[gi]     = eligible[pos_arr[gi]];
        end
    endgenerate

    // Walk downward so the smallest search offset is the one left standing.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                idx   = pos_arr[k];
            end
        end
    end

endmodule

// File: rtl/usb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// usb_tx_arbiter
// Shares one USB TX datapath between NUM_REQ requesters. IDLE picks an
// eligible requester (req high and packet type not NONE), SEND drives the
// latched command until tx_done or watchdog expiry, GAP enforces the
// inter-packet gap before the next pick.
//
// Build option: define USB_TX_ARB_RR_EN for round-robin arbitration
// (search starts after the last granted index). Without it the lowest
// eligible index always wins.
//
// Ports:
//   clk, rst (async, active-high)
//   req/req_packet/req_size/req_data  per-requester request, type, size, byte
//   grant/done/err                    one-hot single-cycle pulses to requesters
//   data_pop                          one-hot byte-consume strobe to owner
//   tx_packet/tx_packet_size          latched command to TX
//   tx_packet_data                    owner's byte, muxed combinationally
//   get_tx_packet_data, tx_done       strobes from TX
//   busy                              not IDLE
// Parameters: NUM_REQ (2..8), IPG_CYCLES (>=1), TIMEOUT_CYCLES (>=2),
//             MAX_SIZE (<=127)
// -----------------------------------------------------------------------------
module usb_tx_arbiter
    import usb_tx_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int IPG_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int MAX_SIZE       = MAX_SIZE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   req_packet,
    input  logic [7*NUM_REQ-1:0]   req_size,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     data_pop,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic [1:0]             tx_packet,
    output logic [6:0]             tx_packet_size,
    output logic [7:0]             tx_packet_data,
    input  logic                   get_tx_packet_data,
    input  logic                   tx_done,
    output logic                   busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IPG_CYCLES - 1);
    localparam logic [6:0]       SIZE_CAP = 7'(MAX_SIZE);

    // Per-requester views of the packed input buses.
    logic [NUM_REQ-1:0] eligible;
    logic [1:0]         pkt_arr  [NUM_REQ];
    logic [6:0]         size_arr [NUM_REQ];
    logic [7:0]         data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign pkt_arr[gi]  = req_packet[2*gi +: 2];
            assign size_arr[gi] = req_size[7*gi +: 7];
            assign data_arr[gi] = req_data[8*gi +: 8];
            assign eligible[gi] = req[gi] && (pkt_arr[gi] != PKT_NONE);
        end
    endgenerate

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [1:0]         pkt_q, pkt_d;
    logic [6:0]         size_q, size_d;
    logic [WD_W-1:0]    wd_cnt_q, wd_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NUM_REQ-1:0] err_q, err_d;
    logic [PTR_W-1:0]   pick_start;
    logic               pick_valid;
    logic [PTR_W-1:0]   pick_idx;
    logic [1:0]         pick_pkt;
    logic [6:0]         pick_size;

`ifdef USB_TX_ARB_RR_EN
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    assign pick_start = rr_ptr_q;
`else
    assign pick_start = '0;
`endif

    usb_tx_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .eligible (eligible),
        .start    (pick_start),
        .valid    (pick_valid),
        .idx      (pick_idx)
    );

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign pick_pkt  = pkt_arr[pick_idx];
    assign pick_size = size_arr[pick_idx];

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        pkt_d     = pkt_q;
        size_d    = size_q;
        wd_cnt_d  = wd_cnt_q;
        gap_cnt_d = gap_cnt_q;
        grant_d   = '0;
        done_d    = '0;
        err_d     = '0;
`ifdef USB_TX_ARB_RR_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = SEND;
                    owner_d  = pick_idx;
                    grant_d  = onehot(pick_idx);
                    pkt_d    = pick_pkt;
                    // Handshakes carry no payload; DATA is clamped to the legal max.
                    if (pick_pkt == PKT_DATA) begin
                        size_d = (pick_size > SIZE_CAP) ? SIZE_CAP : pick_size;
                    end else begin
                        size_d = '0;
                    end
                    wd_cnt_d = '0;
`ifdef USB_TX_ARB_RR_EN
                    rr_ptr_d = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
`endif
                end
            end
            SEND: begin
                // tx_done is tested first so it wins over a same-cycle timeout.
                if (tx_done) begin
                    done_d    = onehot(owner_q);
                    state_d   = GAP;
                    pkt_d     = PKT_NONE;
                    size_d    = '0;
                    gap_cnt_d = '0;
                end else if (wd_cnt_q == WD_LAST) begin
                    err_d     = onehot(owner_q);
                    state_d   = GAP;
                    pkt_d     = PKT_NONE;
                    size_d    = '0;
                    gap_cnt_d = '0;
                end else begin
                    wd_cnt_d  = wd_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            pkt_q     <= PKT_NONE;
            size_q    <= '0;
            wd_cnt_q  <= '0;
            gap_cnt_q <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
`ifdef USB_TX_ARB_RR_EN
            rr_ptr_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            pkt_q     <= pkt_d;
            size_q    <= size_d;
            wd_cnt_q  <= wd_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef USB_TX_ARB_RR_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
        end
    end

    assign grant          = grant_q;
    assign done           = done_q;
    assign err            = err_q;
    assign tx_packet      = pkt_q;
    assign tx_packet_size = size_q;
    assign busy           = (state_q != IDLE);

    // Byte path is only connected while a packet is in flight.
    assign tx_packet_data = (state_q == SEND) ? data_arr[owner_q] : '0;
    assign data_pop       = ((state_q == SEND) && get_tx_packet_data) ? onehot(owner_q) : '0;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_arbiter
// Randomized and directed stimulus for usb_tx_arbiter. The driver predicts
// every grant/pop/done/err event (cycle and contents) from the arbitration,
// gap and watchdog rules and queues it; a monitor compares DUT pulses
// against the queue on every falling edge.
// -----------------------------------------------------------------------------
module tb_usb_tx_arbiter;
    import usb_tx_pkg::*;

    localparam int N    = 3;
    localparam int IPG  = 16;
    localparam int TMO  = 32;
    localparam int MAXS = 64;

    localparam logic [1:0] EV_GRANT = 2'd0;
    localparam logic [1:0] EV_POP   = 2'd1;
    localparam logic [1:0] EV_DONE  = 2'd2;
    localparam logic [1:0] EV_ERR   = 2'd3;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_TMO    = 1;
    localparam int MODE_TERM   = 2;
    localparam int MODE_RAND   = -1;

    typedef struct {
        int         cyc;
        logic [1:0] kind;
        logic [N-1:0] vec;
        logic [1:0] pkt;
        logic [6:0] size;
        logic [7:0] data;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req;
    logic [2*N-1:0] req_packet;
    logic [7*N-1:0] req_size;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   grant, data_pop, done, err;
    logic [1:0]     tx_packet;
    logic [6:0]     tx_packet_size;
    logic [7:0]     tx_packet_data;
    logic           get_tx_packet_data;
    logic           tx_done;
    logic           busy;

    usb_tx_arbiter #(
        .NUM_REQ        (N),
        .IPG_CYCLES     (IPG),
        .TIMEOUT_CYCLES (TMO),
        .MAX_SIZE       (MAXS)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .req                (req),
        .req_packet         (req_packet),
        .req_size           (req_size),
        .req_data           (req_data),
        .grant              (grant),
        .data_pop           (data_pop),
        .done               (done),
        .err                (err),
        .tx_packet          (tx_packet),
        .tx_packet_size     (tx_packet_size),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_done            (tx_done),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  vectors     = 0;
    int  miscompares = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t exp_e;
    int  idle_start  = 0;   // first cycle the arbiter is back in IDLE
    int  rr_ptr      = 0;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    function automatic logic [6:0] exp_size(input logic [1:0] p, input logic [6:0] s);
        if (p != PKT_DATA) return 7'd0;
        return (s > 7'(MAXS)) ? 7'(MAXS) : s;
    endfunction

    function automatic string kname(input logic [1:0] k);
        case (k)
            EV_GRANT: return "grant";
            EV_POP:   return "pop";
            EV_DONE:  return "done";
            default:  return "err";
        endcase
    endfunction

    function automatic ev_t mk_ev(input int c, input logic [1:0] k, input logic [N-1:0] v,
                                  input logic [1:0] p, input logic [6:0] s, input logic [7:0] d);
        ev_t e;
        e.cyc = c; e.kind = k; e.vec = v; e.pkt = p; e.size = s; e.data = d;
        return e;
    endfunction

    // Arbitration rule: first eligible index at or after the start pointer.
    function automatic int model_pick(input logic [N-1:0] pend, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: cycle %0d got %0h required %0h", name, cyc, act, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) req_data[i*8 +: 8] = 8'($urandom);
    endtask

    // Monitor: every DUT pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            obs_q.delete();
            if (grant != '0)    obs_q.push_back(mk_ev(cyc, EV_GRANT, grant, tx_packet, tx_packet_size, 8'h00));
            if (data_pop != '0) obs_q.push_back(mk_ev(cyc, EV_POP, data_pop, tx_packet, tx_packet_size, tx_packet_data));
            if (done != '0)     obs_q.push_back(mk_ev(cyc, EV_DONE, done, tx_packet, 7'd0, 8'h00));
            if (err != '0)      obs_q.push_back(mk_ev(cyc, EV_ERR, err, tx_packet, 7'd0, 8'h00));
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missed_%s: cycle %0d got no pulse required vec=%b", kname(exp_q[0].kind), exp_q[0].cyc, exp_q[0].vec);
                void'(exp_q.pop_front());
            end
            foreach (obs_q[i]) begin
                vectors++;
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    miscompares++;
                    $display("FAIL unexpected_%s: cycle %0d got vec=%b pkt=%0d size=%0d data=%h required no pulse",
                             kname(obs_q[i].kind), cyc, obs_q[i].vec, obs_q[i].pkt, obs_q[i].size, obs_q[i].data);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (obs_q[i].kind !== exp_e.kind || obs_q[i].vec !== exp_e.vec || obs_q[i].pkt !== exp_e.pkt ||
                        obs_q[i].size !== exp_e.size || obs_q[i].data !== exp_e.data) begin
                        miscompares++;
                        $display("FAIL %s: cycle %0d got %s vec=%b pkt=%0d size=%0d data=%h required %s vec=%b pkt=%0d size=%0d data=%h",
                                 kname(exp_e.kind), cyc, kname(obs_q[i].kind), obs_q[i].vec, obs_q[i].pkt, obs_q[i].size,
                                 obs_q[i].data, kname(exp_e.kind), exp_e.vec, exp_e.pkt, exp_e.size, exp_e.data);
                    end
                end
            end
        end
    end

    // Drive one granted packet from its grant cycle g to the end of its gap.
    task automatic serve(input int w, input int g, input logic [1:0] ep, input logic [6:0] es,
                         input int nstr_in, input int mode_in);
        int nstr, mode, endc, r;
        nstr = (nstr_in < 0) ? $urandom_range(0, 6) : nstr_in;
        if (mode_in < 0) begin
            r    = $urandom_range(0, 7);
            mode = (r == 0) ? MODE_TMO : (r == 1) ? MODE_TERM : MODE_NORMAL;
        end else begin
            mode = mode_in;
        end
        goto(g);
        check("busy_in_send", 32'(busy), 32'd1);
        // Owner drops its request and scribbles its command inputs; the latched copy must hold.
        req[w]              = 1'b0;
        req_packet[w*2 +: 2] = 2'($urandom);
        req_size[w*7 +: 7]   = 7'($urandom);
`ifdef USB_TX_ARB_RR_EN
        rr_ptr = (w + 1) % N;
`endif
        step();
        for (int s = 0; s < nstr; s++) begin
            repeat ($urandom_range(0, 2)) step();
            rand_data();
            get_tx_packet_data = 1'b1;
            exp_q.push_back(mk_ev(cyc, EV_POP, onehot(w), ep, es, req_data[w*8 +: 8]));
            step();
            get_tx_packet_data = 1'b0;
        end
        if (mode == MODE_TMO) begin
            endc = g + TMO;
            exp_q.push_back(mk_ev(endc, EV_ERR, onehot(w), PKT_NONE, 7'd0, 8'h00));
            goto(endc);
        end else begin
            if (mode == MODE_TERM) goto(g + TMO - 1);
            tx_done = 1'b1;
            endc    = cyc + 1;
            exp_q.push_back(mk_ev(endc, EV_DONE, onehot(w), PKT_NONE, 7'd0, 8'h00));
            step();
        end
        idle_start = endc + IPG;
        $display("txn owner=%0d type=%0d size=%0d pops=%0d grant_cycle=%0d end_cycle=%0d end=%s",
                 w, ep, es, nstr, g, endc, (mode == MODE_TMO) ? "timeout" : "tx_done");
        // Stray TX strobes through the gap and the first IDLE cycle must be ignored.
        while (cyc <= idle_start) begin
            rand_data();
            get_tx_packet_data = 1'($urandom);
            tx_done            = 1'($urandom);
            #1;
            check("busy_gap_idle", 32'(busy), (cyc < idle_start) ? 32'd1 : 32'd0);
            check("txdata_zero_outside_send", 32'(tx_packet_data), 32'd0);
            check("txpkt_none_outside_send", 32'(tx_packet), 32'(PKT_NONE));
            step();
        end
        get_tx_packet_data = 1'b0;
        tx_done            = 1'b0;
    endtask

    // One arbitration round: raise the given requests and serve every eligible one.
    task automatic round(input logic [N-1:0] act, input logic [2*N-1:0] pk, input logic [7*N-1:0] sz,
                         input int nstr, input int mode);
        logic [N-1:0] pend;
        int c0, w, g;
        req        = act;
        req_packet = pk;
        req_size   = sz;
        c0         = cyc;
        for (int i = 0; i < N; i++) pend[i] = act[i] && (pk[2*i +: 2] != PKT_NONE);
        if (pend == '0) begin
            goto(imax(cyc, idle_start));
            repeat (4) begin
                rand_data();
                get_tx_packet_data = 1'($urandom);
                tx_done            = 1'($urandom);
                #1;
                check("busy_idle_noelig", 32'(busy), 32'd0);
                check("txdata_zero_idle", 32'(tx_packet_data), 32'd0);
                step();
            end
            get_tx_packet_data = 1'b0;
            tx_done            = 1'b0;
        end
        while (pend != '0) begin
            w = model_pick(pend, rr_ptr);
            g = imax(c0, idle_start) + 1;
            exp_q.push_back(mk_ev(g, EV_GRANT, onehot(w), pk[2*w +: 2],
                                  exp_size(pk[2*w +: 2], sz[7*w +: 7]), 8'h00));
            serve(w, g, pk[2*w +: 2], exp_size(pk[2*w +: 2], sz[7*w +: 7]), nstr, mode);
            pend[w] = 1'b0;
        end
        req = '0;
        step();
    endtask

    task automatic reset_test();
        int g;
        req               = 3'b100;
        req_packet[5:4]   = PKT_DATA;
        req_size[20:14]   = 7'd9;
        g = imax(cyc, idle_start) + 1;
        exp_q.push_back(mk_ev(g, EV_GRANT, onehot(2), PKT_DATA, 7'd9, 8'h00));
        goto(g + 3);
        get_tx_packet_data = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("rst_txpkt", 32'(tx_packet), 32'(PKT_NONE));
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pop", 32'(data_pop), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        exp_q.delete();
        step();
        rst                = 1'b0;
        get_tx_packet_data = 1'b0;
        rr_ptr             = 0;
        idle_start         = cyc;
        g                  = cyc + 1;
        exp_q.push_back(mk_ev(g, EV_GRANT, onehot(2), PKT_DATA, 7'd9, 8'h00));
        serve(2, g, PKT_DATA, 7'd9, 2, MODE_NORMAL);
        req = '0;
        step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: cycle %0d got no finish required finish", cyc);
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [N-1:0]   act;
        logic [2*N-1:0] pk;
        logic [7*N-1:0] sz;
        req = '0; req_packet = '0; req_size = '0; req_data = '0;
        get_tx_packet_data = 1'b0; tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({grant, data_pop, done, err}), 32'd0);
        check("reset_txpkt", 32'({tx_packet, tx_packet_size, tx_packet_data}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst        = 1'b0;
        idle_start = cyc;

        round(3'b010, {PKT_NONE, PKT_DATA, PKT_NONE}, {7'd0, 7'd5, 7'd0}, 5, MODE_NORMAL);
        round(3'b101, {PKT_DATA, PKT_NONE, PKT_DATA}, {7'd3, 7'd0, 7'd7}, 2, MODE_NORMAL);
        round(3'b001, {PKT_NONE, PKT_NONE, PKT_ACK},  {7'd0, 7'd0, 7'd40}, 0, MODE_NORMAL);
        round(3'b001, {PKT_NONE, PKT_NONE, PKT_DATA}, {7'd0, 7'd0, 7'd100}, 1, MODE_NORMAL);
        round(3'b100, {PKT_NAK,  PKT_NONE, PKT_NONE}, {7'd77, 7'd0, 7'd0}, 0, MODE_NORMAL);
        round(3'b010, {PKT_NONE, PKT_DATA, PKT_NONE}, {7'd0, 7'd12, 7'd0}, 1, MODE_TMO);
        round(3'b001, {PKT_NONE, PKT_NONE, PKT_DATA}, {7'd0, 7'd0, 7'd1}, 1, MODE_TERM);
        reset_test();
        round(3'b011, {PKT_NONE, PKT_NONE, PKT_NONE}, {7'd4, 7'd4, 7'd4}, 0, MODE_NORMAL);
        repeat (3) round(3'b111, {PKT_DATA, PKT_DATA, PKT_DATA}, {7'd2, 7'd64, 7'd65}, 1, MODE_NORMAL);

        repeat (40) begin
            act = N'($urandom);
            for (int i = 0; i < N; i++) begin
                pk[2*i +: 2] = 2'($urandom);
                sz[7*i +: 7] = 7'($urandom);
            end
            round(act, pk, sz, MODE_RAND, MODE_RAND);
        end

        repeat (3) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
